// File: rtl/mem_access_ctrl.sv
// Request-side controller for the 16x8 data memory. CPU load/store requests are buffered
// in an in-order FIFO and then driven onto the memory strobes. Each load returns one response.
module mem_access_ctrl #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              mem_w,
  output logic              mem_r,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_dataIn,
  input  logic [DATA_W-1:0] mem_dataOut,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t state_q, state_d;

  logic              fifo_we    [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_wdata [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push, pop;

  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              mem_w_d, mem_r_d;
  logic [ADDR_W-1:0] mem_address_d;
  logic [DATA_W-1:0] mem_dataIn_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic [ADDR_W-1:0] rsp_addr_d;

  // A full FIFO refuses a push even when the head is popped in the same cycle.
  assign req_ready = (count != FULL_CNT);
  assign push      = req_valid & req_ready;
  assign pop       = (state_q == IDLE) && (count != '0);
  assign busy      = (count != '0) | (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we[wr_ptr]    <= req_we;
      fifo_addr[wr_ptr]  <= req_addr;
      fifo_wdata[wr_ptr] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    lat_d         = lat_q;
    mem_w_d       = 1'b0;
    mem_r_d       = 1'b0;
    mem_address_d = mem_address;
    mem_dataIn_d  = mem_dataIn;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_addr_d    = rsp_addr;
    case (state_q)
      IDLE: begin
        if (pop) begin
          mem_address_d = fifo_addr[rd_ptr];
          mem_dataIn_d  = fifo_wdata[rd_ptr];
          lat_d         = '0;
          if (fifo_we[rd_ptr]) begin
            state_d = WRITE;
            mem_w_d = 1'b1;
          end else begin
            state_d = READ;
            mem_r_d = 1'b1;
          end
        end
      end
      WRITE: state_d = IDLE;
      READ: begin
        // Read data is sampled on the edge that ends the last strobe cycle.
        if (lat_q == LAT_LAST) begin
          rsp_rdata_d = mem_dataOut;
          rsp_addr_d  = mem_address;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          lat_d   = lat_q + LAT_W'(1);
          mem_r_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      mem_w       <= 1'b0;
      mem_r       <= 1'b0;
      mem_address <= '0;
      mem_dataIn  <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_addr    <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      mem_w       <= mem_w_d;
      mem_r       <= mem_r_d;
      mem_address <= mem_address_d;
      mem_dataIn  <= mem_dataIn_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_addr    <= rsp_addr_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a 16x8 memory, a transaction-level reference model, and a
// per-cycle output compare. It runs directed scenarios first and then a randomized phase.
module tb_mem_access_ctrl;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic rsp_valid, rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] rsp_addr;
  logic mem_w, mem_r, busy;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_dataIn, mem_dataOut;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr),
    .mem_w(mem_w), .mem_r(mem_r), .mem_address(mem_address), .mem_dataIn(mem_dataIn),
    .mem_dataOut(mem_dataOut), .busy(busy)
  );

  // Data memory: asynchronous read, synchronous write.
  logic [DATA_W-1:0] tbmem [16];
  assign mem_dataOut = tbmem[mem_address];
  always @(posedge clk) if (mem_w) tbmem[mem_address] = mem_dataIn;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queued requests plus the one operation in flight.
  typedef struct packed {logic we; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d;} req_t;
  req_t mq[$];
  req_t cur;
  int cur_kind = 0;  // 0 none, 1 store in progress, 2 load in progress
  int cur_cyc = 0;
  bit pend = 1'b0;
  bit m_push;
  logic [DATA_W-1:0] e_rdata = '0, e_din = '0;
  logic [ADDR_W-1:0] e_raddr = '0, e_addr = '0;
  logic [DATA_W-1:0] mref [16];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      cur_kind = 0; cur_cyc = 0; pend = 1'b0;
      e_rdata = '0; e_raddr = '0; e_addr = '0; e_din = '0;
    end else begin
      m_push = req_valid && (mq.size() < FIFO_DEPTH);
      if (pend) begin
        if (rsp_ready) pend = 1'b0;
      end else if (cur_kind == 1) begin
        mref[cur.a] = cur.d;
        cur_kind = 0;
      end else if (cur_kind == 2) begin
        if (cur_cyc == RD_LAT) begin
          pend = 1'b1; e_rdata = mref[cur.a]; e_raddr = cur.a; cur_kind = 0;
        end else cur_cyc++;
      end else if (mq.size() > 0) begin
        cur = mq.pop_front();
        cur_kind = cur.we ? 1 : 2;
        cur_cyc = 1;
        e_addr = cur.a; e_din = cur.d;
      end
      if (m_push) mq.push_back({req_we, req_addr, req_wdata});
    end
  end

  logic [11:0] got[$];
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", req_ready, mq.size() != FIFO_DEPTH);
      chk("mem_w", mem_w, cur_kind == 1);
      chk("mem_r", mem_r, cur_kind == 2);
      chk("mem_address", mem_address, e_addr);
      chk("mem_dataIn", mem_dataIn, e_din);
      chk("rsp_valid", rsp_valid, pend);
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("rsp_addr", rsp_addr, e_raddr);
      chk("busy", busy, (mq.size() != 0) || (cur_kind != 0) || pend);
      if (rsp_valid && rsp_ready) got.push_back({rsp_addr, rsp_rdata});
    end
  end

  task automatic push(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 200);
    if (!req_ready) chk("push_timeout", 32'd0, 32'd1);
    @(posedge clk); #2;
  endtask

  task automatic idle_in();
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while ((busy || rsp_valid) && n < 500);
    if (busy || rsp_valid) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk); #2;
  endtask

  function automatic logic [11:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 12'hFFF;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbmem[i] = {4'hE, 4'(i)};
      mref[i]  = {4'hE, 4'(i)};
    end
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mem_w", mem_w, 0);
    chk("rst_mem_r", mem_r, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Two back-to-back stores: no responses.
    push(1'b1, 4'd3, 8'h03);
    push(1'b1, 4'd7, 8'h07);
    idle_in();
    wait_idle();
    chk("store_no_rsp", got.size(), 0);
    chk("store_mem3", tbmem[3], 8'h03);
    chk("store_mem7", tbmem[7], 8'h07);

    // Two loads return in order.
    push(1'b0, 4'd7, 8'h00);
    push(1'b0, 4'd3, 8'h00);
    idle_in();
    wait_idle();
    chk("load_count", got.size(), 2);
    chk("load_rsp0", got_at(0), 12'h707);
    chk("load_rsp1", got_at(1), 12'h303);
    got.delete();

    // Fill under backpressure, then a pop frees a slot while a push is refused.
    rsp_ready = 1'b0;
    push(1'b0, 4'd1, 8'h00);
    push(1'b0, 4'd2, 8'h00);
    push(1'b0, 4'd4, 8'h00);
    push(1'b0, 4'd5, 8'h00);
    push(1'b0, 4'd6, 8'h00);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd8; req_wdata = 8'h00;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("full_after5", req_ready, 0);
    @(posedge clk); #2;
    @(negedge clk);
    chk("full_at_rsp_accept", req_ready, 0);
    @(posedge clk); #2;
    @(negedge clk);
    chk("pop_frees_slot", req_ready, 1);
    @(posedge clk); #2;
    idle_in();
    wait_idle();
    chk("drain_count", got.size(), 6);
    chk("drain_rsp0", got_at(0), 12'h1E1);
    chk("drain_rsp1", got_at(1), 12'h2E2);
    chk("drain_rsp2", got_at(2), 12'h4E4);
    chk("drain_rsp3", got_at(3), 12'h5E5);
    chk("drain_rsp4", got_at(4), 12'h6E6);
    chk("drain_rsp5", got_at(5), 12'h8E8);
    got.delete();

    // Read-after-write to the same address.
    push(1'b1, 4'd9, 8'hA5);
    push(1'b0, 4'd9, 8'h00);
    idle_in();
    wait_idle();
    chk("raw_rsp", got_at(0), 12'h9A5);
    got.delete();

    // Reset during a read aborts it; memory survives.
    push(1'b0, 4'd3, 8'h00);
    idle_in();
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_r && n < 50);
      chk("reach_read", mem_r, 1);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("arst_mem_r", mem_r, 0);
    chk("arst_mem_address", mem_address, 0);
    chk("arst_mem_dataIn", mem_dataIn, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_rdata", rsp_rdata, 0);
    chk("arst_rsp_addr", rsp_addr, 0);
    chk("arst_busy", busy, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    chk("arst_no_rsp", got.size(), 0);
    push(1'b0, 4'd3, 8'h00);
    idle_in();
    wait_idle();
    chk("post_rst_load", got_at(0), 12'h303);
    got.delete();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 99) < 60);
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 4'($urandom_range(0, 15));
      req_wdata = 8'($urandom_range(0, 255));
      rsp_ready = ($urandom_range(0, 99) < 70);
      @(posedge clk); #2;
    end
    idle_in();
    rsp_ready = 1'b1;
    wait_idle();
    chk("final_busy", busy, 0);
    chk("final_req_ready", req_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
